fp32_add_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder/subtractor with a start/done handshake.
- Consumes the FLOAT1/FLOAT2 operand registers of the UDM CSR block and produces the word returned at RES_ADDR, replacing the free-running float_math path.
- The CSR block pulses start_i on a write to FLOAT2; software polls busy/done through a status CSR.
- Fixed latency, fully synchronous, one operation in flight.

---
 rtl/fp32_add_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_fp32_add_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp32_add_seq.sv
// fp32_add_seq: multi-cycle IEEE-754 binary32 adder/subtractor, one operation in flight.
// Latency: done_o pulses 5 cycles after start_i is sampled in IDLE (back-to-back every 6 cycles).
// Backpressure: none; start_i is ignored (not queued) while busy_o is high.
//
// Ports:
//   clk_gen, srst      clock; synchronous active-high reset
//   start_i            launch; sampled only in IDLE (including the cycle done_o is high)
//   op_a_i, op_b_i     binary32 operands, captured on accepted start
//   sub_i              1: A-B, 0: A+B
//   busy_o             high from the cycle after start is accepted until done_o
//   done_o             one-cycle pulse; result_o/flags_o valid from this cycle
//   result_o           result, held until the next result is packed
//   flags_o            [0] invalid, [1] overflow, [2] underflow/flush, [3] inexact
//
// Build option: define FP32_ADD_SEQ_RNE_EN for round-to-nearest-even with overflow to
// infinity; otherwise results truncate toward zero and overflow saturates to max finite.
module fp32_add_seq (
  input  logic        clk_gen,
  input  logic        srst,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        sub_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  // Fixed pipeline depth; one FSM state per cycle plus IDLE.
  localparam int LATENCY = 5;
  localparam int ST_W    = $clog2(LATENCY + 1);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_PACK
  } state_t;

  state_t state, state_nxt;
  logic   busy_nxt, done_nxt;

  // Captured operands
  logic [31:0] a_q, b_q;
  logic        sub_q;

  // UNPACK results
  logic        sign_a_u, sign_b_u;
  logic [7:0]  exp_a_u, exp_b_u;
  logic [23:0] mant_a_u, mant_b_u;
  logic        spec_vld;
  logic [31:0] spec_res;
  logic [3:0]  spec_flg;

  // ALIGN results: mantissas are {hidden, frac[22:0], guard, round, sticky}
  logic        sign_l, sign_s;
  logic [7:0]  exp_l;
  logic [26:0] mant_l, mant_s;

  // ADD results
  logic [27:0]        sum_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;

  // NORM results
  logic [26:0]        mant_n;
  logic signed [9:0]  exp_n;
  logic               sign_n;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= busy_nxt;
      done_o <= done_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_ALIGN;
      ST_ALIGN:  state_nxt = ST_ADD;
      ST_ADD:    state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_PACK;
      ST_PACK:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (registered next cycle, so done_o lands in the IDLE cycle after PACK)
  always_comb begin
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_PACK);
  end

  // ---------------------------------------------------------------------------
  // UNPACK: classify, flush denormals, insert hidden bit
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        sgn_b_eff;
  logic        nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
  logic        spec_vld_d;
  logic [31:0] spec_res_d;
  logic [3:0]  spec_flg_d;

  always_comb begin
    exp_a     = a_q[30:23];
    frac_a    = a_q[22:0];
    exp_b     = b_q[30:23];
    frac_b    = b_q[22:0];
    sgn_b_eff = b_q[31] ^ sub_q;
    nan_a     = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b     = (exp_b == 8'hFF) && (frac_b != 23'd0);
    snan_a    = nan_a && !frac_a[22];
    snan_b    = nan_b && !frac_b[22];
    inf_a     = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b     = (exp_b == 8'hFF) && (frac_b == 23'd0);

    spec_vld_d = 1'b0;
    spec_res_d = 32'd0;
    spec_flg_d = 4'd0;
    if (nan_a || nan_b) begin
      spec_vld_d = 1'b1;
      spec_res_d = QNAN;
      spec_flg_d = {3'b000, snan_a | snan_b};
    end else if (inf_a && inf_b && (a_q[31] != sgn_b_eff)) begin
      spec_vld_d = 1'b1;
      spec_res_d = QNAN;
      spec_flg_d = 4'b0001;
    end else if (inf_a) begin
      spec_vld_d = 1'b1;
      spec_res_d = {a_q[31], 8'hFF, 23'd0};
    end else if (inf_b) begin
      spec_vld_d = 1'b1;
      spec_res_d = {sgn_b_eff, 8'hFF, 23'd0};
    end
  end

  // ---------------------------------------------------------------------------
  // ALIGN: order by magnitude, shift the smaller operand right in one step
  // ---------------------------------------------------------------------------
  logic        a_ge_b;
  logic [7:0]  exp_big, exp_sml, diff;
  logic [23:0] m_big, m_sml;
  logic [26:0] full_sml, shifted, sml_al;
  logic        lost;

  always_comb begin
    // Denormals were flushed to exp=0/mant=0, so {exp,mant} orders magnitudes correctly.
    a_ge_b   = {exp_a_u, mant_a_u} >= {exp_b_u, mant_b_u};
    exp_big  = a_ge_b ? exp_a_u  : exp_b_u;
    exp_sml  = a_ge_b ? exp_b_u  : exp_a_u;
    m_big    = a_ge_b ? mant_a_u : mant_b_u;
    m_sml    = a_ge_b ? mant_b_u : mant_a_u;
    diff     = exp_big - exp_sml;
    full_sml = {m_sml, 3'b000};
    shifted  = full_sml >> diff[4:0];
    lost     = |(full_sml & ~(27'h7FF_FFFF << diff[4:0]));
    if (diff > 8'd26) begin
      // Shifted entirely past the round bit: only its existence survives, as sticky.
      sml_al = {26'd0, |m_sml};
    end else begin
      sml_al = {shifted[26:1], shifted[0] | lost};
    end
  end

  // ---------------------------------------------------------------------------
  // ADD: magnitude add/subtract; larger operand first so the difference is >= 0
  // ---------------------------------------------------------------------------
  logic [27:0] sum_d;
  logic        sign_d;

  always_comb begin
    if (sign_l ^ sign_s) begin
      sum_d = {1'b0, mant_l} - {1'b0, mant_s};
    end else begin
      sum_d = {1'b0, mant_l} + {1'b0, mant_s};
    end
    // Exact zero is +0 unless both operands were -0.
    sign_d = (sum_d == 28'd0) ? (sign_l & sign_s) : sign_l;
  end

  // ---------------------------------------------------------------------------
  // NORM: one-step normalise, right on carry or left by leading-zero count
  // ---------------------------------------------------------------------------
  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       mant_nd;
  logic signed [9:0] exp_nd;

  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum_r[i]) begin
        lzc      = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
    if (sum_r[27]) begin
      mant_nd = {sum_r[27:2], sum_r[1] | sum_r[0]};
      exp_nd  = exp_r + 10'sd1;
    end else begin
      mant_nd = sum_r[26:0] << lzc;
      exp_nd  = exp_r - $signed({5'd0, lzc});
    end
  end

  // ---------------------------------------------------------------------------
  // PACK: round, range check, assemble
  // ---------------------------------------------------------------------------
  logic [22:0]       frac_p;
  logic signed [9:0] exp_p;
  logic [31:0]       ovf_res;
  logic              inexact;
  logic [31:0]       res_d;
  logic [3:0]        flg_d;
`ifdef FP32_ADD_SEQ_RNE_EN
  logic              round_up;
  logic [24:0]       rnd;
`endif

  always_comb begin
`ifdef FP32_ADD_SEQ_RNE_EN
    // Round up above half, or exactly half with an odd LSB.
    round_up = mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
    rnd      = {1'b0, mant_n[26:3]} + {24'd0, round_up};
    frac_p   = rnd[24] ? rnd[23:1] : rnd[22:0];
    exp_p    = exp_n + $signed({9'd0, rnd[24]});
    ovf_res  = {sign_n, 8'hFF, 23'd0};
`else
    frac_p   = mant_n[25:3];
    exp_p    = exp_n;
    ovf_res  = {sign_n, 8'hFE, 23'h7F_FFFF};
`endif
    inexact = |mant_n[2:0];

    // A normalised nonzero magnitude always has the hidden bit set.
    if (!mant_n[26]) begin
      res_d = {sign_n, 31'd0};
      flg_d = 4'b0000;
    end else if (exp_p >= 10'sd255) begin
      res_d = ovf_res;
      flg_d = 4'b1010;
    end else if (exp_p <= 10'sd0) begin
      res_d = {sign_n, 31'd0};
      flg_d = 4'b1100;
    end else begin
      res_d = {sign_n, exp_p[7:0], frac_p};
      flg_d = {inexact, 3'b000};
    end

    if (spec_vld) begin
      res_d = spec_res;
      flg_d = spec_flg;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: each stage writes only in its own state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sub_q    <= 1'b0;
      sign_a_u <= 1'b0;
      sign_b_u <= 1'b0;
      exp_a_u  <= 8'd0;
      exp_b_u  <= 8'd0;
      mant_a_u <= 24'd0;
      mant_b_u <= 24'd0;
      spec_vld <= 1'b0;
      spec_res <= 32'd0;
      spec_flg <= 4'd0;
      sign_l   <= 1'b0;
      sign_s   <= 1'b0;
      exp_l    <= 8'd0;
      mant_l   <= 27'd0;
      mant_s   <= 27'd0;
      sum_r    <= 28'd0;
      sign_r   <= 1'b0;
      exp_r    <= 10'sd0;
      mant_n   <= 27'd0;
      exp_n    <= 10'sd0;
      sign_n   <= 1'b0;
      result_o <= 32'd0;
      flags_o  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            a_q   <= op_a_i;
            b_q   <= op_b_i;
            sub_q <= sub_i;
          end
        end
        ST_UNPACK: begin
          sign_a_u <= a_q[31];
          sign_b_u <= sgn_b_eff;
          exp_a_u  <= exp_a;
          exp_b_u  <= exp_b;
          mant_a_u <= (exp_a == 8'd0) ? 24'd0 : {1'b1, frac_a};
          mant_b_u <= (exp_b == 8'd0) ? 24'd0 : {1'b1, frac_b};
          spec_vld <= spec_vld_d;
          spec_res <= spec_res_d;
          spec_flg <= spec_flg_d;
        end
        ST_ALIGN: begin
          sign_l <= a_ge_b ? sign_a_u : sign_b_u;
          sign_s <= a_ge_b ? sign_b_u : sign_a_u;
          exp_l  <= exp_big;
          mant_l <= {m_big, 3'b000};
          mant_s <= sml_al;
        end
        ST_ADD: begin
          sum_r  <= sum_d;
          sign_r <= sign_d;
          exp_r  <= $signed({2'b00, exp_l});
        end
        ST_NORM: begin
          mant_n <= mant_nd;
          exp_n  <= exp_nd;
          sign_n <= sign_r;
        end
        ST_PACK: begin
          result_o <= res_d;
          flags_o  <= flg_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_seq.sv
// tb_fp32_add_seq: directed vectors with hand-computed results for fp32_add_seq,
// plus handshake, ignored-start, back-to-back and mid-operation reset sequences.
// Expected rounding/overflow results follow the FP32_ADD_SEQ_RNE_EN build option.
module tb_fp32_add_seq;

  logic        clk_gen = 1'b0;
  logic        srst;
  logic        start_i;
  logic [31:0] op_a_i, op_b_i;
  logic        sub_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  always #5 clk_gen = ~clk_gen;

  fp32_add_seq dut (
    .clk_gen  (clk_gen),
    .srst     (srst),
    .start_i  (start_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .sub_i    (sub_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

`ifdef FP32_ADD_SEQ_RNE_EN
  localparam logic [31:0] OVF_P = 32'h7F80_0000;
  localparam logic [31:0] OVF_N = 32'hFF80_0000;
  localparam logic [31:0] RND_A = 32'h3F80_0001;
  localparam logic [31:0] RND_C = 32'h4000_0000;
`else
  localparam logic [31:0] OVF_P = 32'h7F7F_FFFF;
  localparam logic [31:0] OVF_N = 32'hFF7F_FFFF;
  localparam logic [31:0] RND_A = 32'h3F80_0000;
  localparam logic [31:0] RND_C = 32'h3FFF_FFFF;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Launch one operation, check the busy/done timeline, return the result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic [3:0] flg);
    @(negedge clk_gen);
    op_a_i  = a;
    op_b_i  = b;
    sub_i   = sub;
    start_i = 1'b1;
    @(posedge clk_gen);
    #1;
    start_i = 1'b0;
    // Operands are don't-care once captured.
    op_a_i  = ~a;
    op_b_i  = $urandom;
    sub_i   = ~sub;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_gen);
      #1;
      if (k < 5) begin
        check($sformatf("busy at T+%0d", k), {31'd0, busy_o}, 32'd1);
        check($sformatf("done at T+%0d", k), {31'd0, done_o}, 32'd0);
      end else begin
        check("done at T+5", {31'd0, done_o}, 32'd1);
        check("busy at T+5", {31'd0, busy_o}, 32'd0);
      end
    end
    res = result_o;
    flg = flags_o;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          seen_done;

    srst    = 1'b1;
    start_i = 1'b0;
    op_a_i  = 32'd0;
    op_b_i  = 32'd0;
    sub_i   = 1'b0;

    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'h0}; // 1+2
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 4'h0}; // x-x
    vecs[2]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 4'h1}; // inf+-inf
    vecs[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, OVF_P,         4'hA}; // +overflow
    vecs[4]  = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, OVF_N,         4'hA}; // -overflow
    vecs[5]  = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, RND_A,         4'h8}; // above half
    vecs[6]  = '{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'h8}; // tie, even
    vecs[7]  = '{32'h3FFF_FFFF, 32'h33C0_0000, 1'b0, RND_C,         4'h8}; // round carry
    vecs[8]  = '{32'h3F80_0000, 32'h3F40_0000, 1'b1, 32'h3E80_0000, 4'h0}; // 1-0.75
    vecs[9]  = '{32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 4'h0}; // -2+1
    vecs[10] = '{32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'h0}; // qNaN
    vecs[11] = '{32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'h1}; // sNaN
    vecs[12] = '{32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 4'h0}; // 1-(-inf)
    vecs[13] = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'h1}; // inf-inf
    vecs[14] = '{32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'h0}; // denormal
    vecs[15] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'h0}; // -0+-0
    vecs[16] = '{32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 4'hC}; // underflow
    vecs[17] = '{32'h3F80_0000, 32'h2F80_0000, 1'b0, 32'h3F80_0000, 4'h8}; // sticky only
    vecs[18] = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 4'h0}; // -inf+1
    vecs[19] = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 4'h0}; // 1+-1

    // Reset state
    repeat (3) @(posedge clk_gen);
    #1;
    check("reset busy",   {31'd0, busy_o}, 32'd0);
    check("reset done",   {31'd0, done_o}, 32'd0);
    check("reset result", result_o,       32'd0);
    check("reset flags",  {28'd0, flags_o}, 32'd0);
    @(negedge clk_gen);
    srst = 1'b0;

    // Directed vectors; consecutive ops start in the done cycle of the previous one.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, f);
      check($sformatf("vec%0d result", i), r, vecs[i].res);
      check($sformatf("vec%0d flags", i), {28'd0, f}, {28'd0, vecs[i].flg});
    end

    // Start while busy is ignored; start during done launches the next op.
    @(negedge clk_gen);
    op_a_i  = 32'h3F80_0000;
    op_b_i  = 32'h4000_0000;
    sub_i   = 1'b0;
    start_i = 1'b1;
    @(posedge clk_gen);                   // edge T
    #1;
    start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_gen);
      #1;
      start_i = (k == 1);                 // sampled at edge T+2, while busy
      if (k == 1) begin
        op_a_i = 32'h3F80_0000;
        op_b_i = 32'h3F40_0000;
        sub_i  = 1'b1;
      end
      if (k < 5) check($sformatf("hs done at T+%0d", k), {31'd0, done_o}, 32'd0);
    end
    check("hs done at T+5", {31'd0, done_o}, 32'd1);
    check("hs ignored-start result", result_o, 32'h4040_0000);
    start_i = 1'b1;                       // sampled at edge T+6, in IDLE
    for (int k = 6; k <= 11; k++) begin
      @(posedge clk_gen);
      #1;
      start_i = 1'b0;
      check($sformatf("b2b done at T+%0d", k), {31'd0, done_o}, (k == 11) ? 32'd1 : 32'd0);
    end
    check("b2b result", result_o, 32'h3E80_0000);

    // Reset mid-operation
    @(negedge clk_gen);
    op_a_i  = 32'h3F80_0000;
    op_b_i  = 32'h4000_0000;
    sub_i   = 1'b0;
    start_i = 1'b1;
    @(posedge clk_gen);                   // edge T
    #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_gen);        // edge T+2
    #1;
    srst = 1'b1;
    @(posedge clk_gen);                   // edge T+3 samples srst
    #1;
    check("mid-reset busy",   {31'd0, busy_o}, 32'd0);
    check("mid-reset done",   {31'd0, done_o}, 32'd0);
    check("mid-reset result", result_o,       32'd0);
    srst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_gen);
      #1;
      if (done_o === 1'b1) seen_done++;
    end
    check("aborted op done pulses", seen_done, 0);
    run_op(32'h3F80_0000, 32'h3F40_0000, 1'b1, r, f);
    check("post-reset result", r, 32'h3E80_0000);
    check("post-reset flags", {28'd0, f}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
